audio_xfade_router: RTL and testbench

- Parametrised successor to the fixed two-way original/modified audio select between the SPI receive path, the effect modules and the DAC driver.
- Routes one of NUM_SRC signed sample streams to the DAC path.
- Every source change is a linear crossfade over 2^FADE_LOG2 samples, not a hard switch, so there are no clicks.
- Sample-rate timing comes from the receiver's data-ready signal.

---
 rtl/audio_xfade_router.sv | 181 ++++++++++++++++++
 tb/tb_audio_xfade_router.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_xfade_router.sv
// N-way signed audio source router with a linear crossfade on every source change, paced by data_ready rising edges.
// Optional macro FXR_MUTE_RAMP_EN adds mute_in and a 2^FADE_LOG2-step gain ramp stage (latency 3 instead of 2).
module audio_xfade_router #(
    parameter int clock_max = 25_000_000,
    parameter int DATA_W    = 16,
    parameter int NUM_SRC   = 2,
    parameter int FADE_LOG2 = 6
) (
    input  logic                          clk_25mhz,
    input  logic                          reset,
    input  logic                          data_ready,
    input  logic [NUM_SRC*DATA_W-1:0]     src_audio_in,
    input  logic [$clog2(NUM_SRC)-1:0]    src_sel,
`ifdef FXR_MUTE_RAMP_EN
    input  logic                          mute_in,
`endif
    output logic signed [DATA_W-1:0]      audio_out,
    output logic                          audio_valid_out,
    output logic                          fading,
    output logic [$clog2(NUM_SRC)-1:0]    cur_sel
);

    localparam int SEL_W  = $clog2(NUM_SRC);
    localparam int KW     = FADE_LOG2 + 1;
    localparam int PROD_W = DATA_W + FADE_LOG2 + 1;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic [KW-1:0] FULL_W = KW'(1 << FADE_LOG2);

    if (NUM_SRC < 2 || FADE_LOG2 < 1 || FADE_LOG2 > 8 || clock_max <= 0) begin : g_param_check
        $error("audio_xfade_router: parameter out of range");
    end

    typedef enum logic {STEADY, FADING} state_t;

    state_t                     state_q, state_d;
    logic [SEL_W-1:0]           cur_q, cur_d, next_q, next_d;
    logic [KW-1:0]              k_q, k_d, kNext, wA, wB;
    logic                       dr_q, strobe;
    logic signed [DATA_W-1:0]   srcA, srcB;
    logic signed [PROD_W-1:0]   aExt, bExt, wAExt, wBExt;
    logic signed [PROD_W-1:0]   prodA_q, prodB_q;
    logic signed [SUM_W-1:0]    sumAB;
    logic                       v1_q, valid_q;
    logic signed [DATA_W-1:0]   audio_q;

    assign strobe = data_ready & ~dr_q;

    always_comb begin
        srcA = '0;
        srcB = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cur_q == SEL_W'(i))  srcA = src_audio_in[i*DATA_W +: DATA_W];
            if (next_q == SEL_W'(i)) srcB = src_audio_in[i*DATA_W +: DATA_W];
        end
    end

    // wB is the weight of the incoming source for the sample taken on this strobe.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        next_d  = next_q;
        k_d     = k_q;
        kNext   = k_q + KW'(1);
        wB      = '0;
        if (strobe) begin
            case (state_q)
                STEADY: begin
                    if (src_sel != cur_q && int'(src_sel) < NUM_SRC) begin
                        next_d  = src_sel;
                        k_d     = '0;
                        state_d = FADING;
                    end
                end
                FADING: begin
                    wB = kNext;
                    if (kNext == FULL_W) begin
                        cur_d   = next_q;
                        k_d     = '0;
                        state_d = STEADY;
                    end else begin
                        k_d = kNext;
                    end
                end
                default: state_d = STEADY;
            endcase
        end
    end

    assign wA    = FULL_W - wB;
    assign aExt  = PROD_W'(srcA);
    assign bExt  = PROD_W'(srcB);
    assign wAExt = PROD_W'({1'b0, wA});
    assign wBExt = PROD_W'({1'b0, wB});
    assign sumAB = SUM_W'(prodA_q) + SUM_W'(prodB_q);

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            dr_q    <= 1'b0;
            state_q <= STEADY;
            cur_q   <= '0;
            next_q  <= '0;
            k_q     <= '0;
            prodA_q <= '0;
            prodB_q <= '0;
            v1_q    <= 1'b0;
        end else begin
            dr_q    <= data_ready;
            state_q <= state_d;
            cur_q   <= cur_d;
            next_q  <= next_d;
            k_q     <= k_d;
            v1_q    <= strobe;
            if (strobe) begin
                prodA_q <= aExt * wAExt;
                prodB_q <= bExt * wBExt;
            end
        end
    end

`ifdef FXR_MUTE_RAMP_EN
    localparam int GAIN_W = DATA_W + KW + 1;

    logic [KW-1:0]            g_q, gNext, g1_q, g2_q;
    logic signed [DATA_W-1:0] mix_q;
    logic                     v2_q;
    logic signed [GAIN_W-1:0] mixExt, gExt;

    always_comb begin
        gNext = g_q;
        if (strobe) begin
            if (mute_in) begin
                if (g_q != '0) gNext = g_q - KW'(1);
            end else if (g_q != FULL_W) begin
                gNext = g_q + KW'(1);
            end
        end
    end

    assign mixExt = GAIN_W'(mix_q);
    assign gExt   = GAIN_W'({1'b0, g2_q});

    // The gain travels with its sample so a fast strobe rate cannot misalign them.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            g_q     <= FULL_W;
            g1_q    <= FULL_W;
            g2_q    <= FULL_W;
            mix_q   <= '0;
            v2_q    <= 1'b0;
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            g_q     <= gNext;
            v2_q    <= v1_q;
            valid_q <= v2_q;
            if (strobe) g1_q <= gNext;
            if (v1_q) begin
                mix_q <= DATA_W'(sumAB >>> FADE_LOG2);
                g2_q  <= g1_q;
            end
            if (v2_q) audio_q <= DATA_W'((mixExt * gExt) >>> FADE_LOG2);
        end
    end
`else
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            audio_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= v1_q;
            if (v1_q) audio_q <= DATA_W'(sumAB >>> FADE_LOG2);
        end
    end
`endif

    assign audio_out       = audio_q;
    assign audio_valid_out = valid_q;
    assign fading          = (state_q == FADING);
    assign cur_sel         = cur_q;

endmodule

// File: tb/tb_audio_xfade_router.sv
// Directed bench for audio_xfade_router: a 2-source and a 3-source instance, both with FADE_LOG2=2.
// With FXR_MUTE_RAMP_EN defined, the mute ramp sequence is exercised too.
module tb_audio_xfade_router;

`ifdef FXR_MUTE_RAMP_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               dr;
    logic               mute;
    logic [31:0]        src2;
    logic [0:0]         sel2;
    logic signed [15:0] out2;
    logic               v2, fade2;
    logic [0:0]         cur2;
    logic [47:0]        src3;
    logic [1:0]         sel3;
    logic signed [15:0] out3;
    logic               v3, fade3;
    logic [1:0]         cur3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_xfade_router #(.DATA_W(16), .NUM_SRC(2), .FADE_LOG2(2)) dut2 (
        .clk_25mhz(clk), .reset(reset), .data_ready(dr),
        .src_audio_in(src2), .src_sel(sel2),
`ifdef FXR_MUTE_RAMP_EN
        .mute_in(mute),
`endif
        .audio_out(out2), .audio_valid_out(v2), .fading(fade2), .cur_sel(cur2)
    );

    audio_xfade_router #(.DATA_W(16), .NUM_SRC(3), .FADE_LOG2(2)) dut3 (
        .clk_25mhz(clk), .reset(reset), .data_ready(dr),
        .src_audio_in(src3), .src_sel(sel3),
`ifdef FXR_MUTE_RAMP_EN
        .mute_in(mute),
`endif
        .audio_out(out3), .audio_valid_out(v3), .fading(fade3), .cur_sel(cur3)
    );

    typedef struct {
        int s0;
        int s1;
        int sel;
        int expOut;
        int expFade;
        int expCur;
    } vec_t;

    vec_t vecs[8];

    int sel3Seq[11]  = '{1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};
    int out3Seq[11]  = '{10, 12, 15, 17, 20, 20, 22, 25, 27, 30, 30};
    int fade3Seq[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0};
    int cur3Seq[11]  = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2};

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One data_ready pulse, returning at the negedge where the result is valid.
    task automatic applyStimulus();
        dr = 1'b1;
        @(negedge clk);
        dr = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        checkOutput("valid2", int'(v2), 1);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic setSrc2(input int s0, input int s1);
        src2 = {16'(s1), 16'(s0)};
    endtask

    initial begin
        int pulses;
        int pulseAt;

        reset = 1'b1;
        dr    = 1'b0;
        mute  = 1'b0;
        src2  = '0;
        sel2  = '0;
        src3  = '0;
        sel3  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_out", int'(out2), 0);
        checkOutput("reset_valid", int'(v2), 0);
        checkOutput("reset_fading", int'(fade2), 0);
        checkOutput("reset_cur", int'(cur2), 0);
        reset = 1'b0;
        @(negedge clk);

        vecs[0] = '{1000, -1000, 0, 1000, 0, 0};
        vecs[1] = '{1000, -1000, 1, 1000, 1, 0};
        vecs[2] = '{1000, -1000, 1, 500, 1, 0};
        vecs[3] = '{1000, -1000, 1, 0, 1, 0};
        vecs[4] = '{1000, -1000, 1, -500, 1, 0};
        vecs[5] = '{1000, -1000, 1, -1000, 0, 1};
        vecs[6] = '{1000, -777, 1, -777, 0, 1};
        vecs[7] = '{5, -8, 0, -8, 1, 1};

        for (int i = 0; i < 8; i++) begin
            setSrc2(vecs[i].s0, vecs[i].s1);
            sel2 = 1'(vecs[i].sel);
            applyStimulus();
            checkOutput($sformatf("vec%0d_out", i), int'(out2), vecs[i].expOut);
            checkOutput($sformatf("vec%0d_fading", i), int'(fade2), vecs[i].expFade);
            checkOutput($sformatf("vec%0d_cur", i), int'(cur2), vecs[i].expCur);
        end
        @(negedge clk);
        checkOutput("idle_valid", int'(v2), 0);

        // dut2 is mid-fade (1 -> 0) here; reset must abort it asynchronously.
        reset = 1'b1;
        #1;
        checkOutput("midreset_fading", int'(fade2), 0);
        checkOutput("midreset_cur", int'(cur2), 0);
        checkOutput("midreset_out", int'(out2), 0);
        @(negedge clk);
        reset = 1'b0;
        setSrc2(100, 0);
        sel2 = 1'b0;
        applyStimulus();
        checkOutput("after_reset_out", int'(out2), 100);

        doReset();
        setSrc2(3, 0);
        sel2 = 1'b1;
        applyStimulus();
        checkOutput("round_pos_k0", int'(out2), 3);
        applyStimulus();
        checkOutput("round_pos_k1", int'(out2), 2);
        doReset();
        setSrc2(-3, 0);
        applyStimulus();
        checkOutput("round_neg_k0", int'(out2), -3);
        applyStimulus();
        checkOutput("round_neg_k1", int'(out2), -3);

        doReset();
        sel2 = 1'b0;
        pulses  = 0;
        pulseAt = -1;
        @(negedge clk);
        dr = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 10) dr = 1'b0;
            if (v2) begin
                pulses++;
                if (pulseAt < 0) pulseAt = i;
            end
        end
        checkOutput("held_high_pulses", pulses, 1);
        checkOutput("held_high_latency", pulseAt, LAT);

        doReset();
        src3 = {16'sd30, 16'sd20, 16'sd10};
        for (int i = 0; i < 11; i++) begin
            sel3 = 2'(sel3Seq[i]);
            applyStimulus();
            checkOutput($sformatf("three_%0d_valid", i), int'(v3), 1);
            checkOutput($sformatf("three_%0d_out", i), int'(out3), out3Seq[i]);
            checkOutput($sformatf("three_%0d_fading", i), int'(fade3), fade3Seq[i]);
            checkOutput($sformatf("three_%0d_cur", i), int'(cur3), cur3Seq[i]);
        end

`ifdef FXR_MUTE_RAMP_EN
        begin
            int muteExp[9] = '{300, 200, 100, 0, 0, 100, 200, 300, 400};
            doReset();
            setSrc2(400, 0);
            sel2 = 1'b0;
            for (int i = 0; i < 9; i++) begin
                mute = (i < 5);
                applyStimulus();
                checkOutput($sformatf("mute_%0d_out", i), int'(out2), muteExp[i]);
            end
            mute = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
